// File: rtl/mul_mantissa_seq.sv
// Sequential shift-and-add multiplier for 24-bit significands (hidden bit included).
// One 25-bit add plus a one-bit right shift per cycle; 48-bit raw product out.

module add_25bits (
    input  logic [24:0] a,
    input  logic [24:0] b,
    input  logic        cin,
    output logic [24:0] sum
);
    assign sum = a + b + {24'd0, cin};
endmodule

module mul_mantissa_seq (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [23:0] i_data_one,
    input  logic [23:0] i_data_two,
    input  logic        i_valid,
    output logic        o_ready,
    output logic [47:0] o_product,
    output logic        o_valid,
    input  logic        i_ready
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_nxt;
    logic [23:0] mcand;
    logic [23:0] mplr;
    logic [24:0] acc;
    logic [24:0] addend;
    logic [24:0] sum;
    logic [4:0]  cnt;
    logic [47:0] prod_q;
    logic        last_iter;

    assign addend    = mplr[0] ? {1'b0, mcand} : '0;
    // Codes 24..31 are unreachable but still leave CALC on the next edge.
    assign last_iter = (cnt >= 5'd23);

    add_25bits u_add (
        .a   (acc),
        .b   (addend),
        .cin (1'b0),
        .sum (sum)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        o_ready   = 1'b0;
        o_valid   = 1'b0;
        case (state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) state_nxt = CALC;
            end
            CALC: begin
                if (last_iter) state_nxt = DONE;
            end
            DONE: begin
                o_valid = 1'b1;
                if (i_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The product is captured separately so it holds across IDLE and the next CALC;
    // on the final step the shifted {acc[23:0], mplr} equals {sum, mplr[23:1]}.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mcand  <= '0;
            mplr   <= '0;
            acc    <= '0;
            cnt    <= '0;
            prod_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        mcand <= i_data_one;
                        mplr  <= i_data_two;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                CALC: begin
                    acc  <= {1'b0, sum[24:1]};
                    mplr <= {sum[0], mplr[23:1]};
                    cnt  <= cnt + 5'd1;
                    if (last_iter) prod_q <= {sum, mplr[23:1]};
                end
                default: ;
            endcase
        end
    end

    assign o_product = prod_q;

endmodule

// File: tb/tb_mul_mantissa_seq.sv
// Scoreboard bench for mul_mantissa_seq: driver pushes a*b, monitor checks on o_valid.

module tb_mul_mantissa_seq;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [23:0] i_data_one = '0;
    logic [23:0] i_data_two = '0;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b0;
    logic        o_ready;
    logic        o_valid;
    logic [47:0] o_product;

    mul_mantissa_seq dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_data_one (i_data_one),
        .i_data_two (i_data_two),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .o_product  (o_product),
        .o_valid    (o_valid),
        .i_ready    (i_ready)
    );

    always #5 i_clk = ~i_clk;

    int unsigned cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int          checks = 0;
    int          errors = 0;
    logic [47:0] exp_q[$];
    int unsigned acc_q[$];

    task automatic check48(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic checkint(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        logic        prev_valid;
        logic        hs_prev;
        logic [47:0] held;
        logic [47:0] e;
        int unsigned t;
        prev_valid = 1'b0;
        hs_prev    = 1'b0;
        held       = '0;
        forever begin
            @(negedge i_clk);
            if (!i_rst_n) begin
                prev_valid = 1'b0;
                hs_prev    = 1'b0;
            end else begin
                if (hs_prev) begin
                    check1("ready_after_hs", o_ready, 1'b1);
                    check1("valid_after_hs", o_valid, 1'b0);
                    check48("hold_after_hs", o_product, held);
                end
                if (o_valid) begin
                    check1("ready_while_valid", o_ready, 1'b0);
                    if (!prev_valid) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_valid actual=%h required=no_output", o_product);
                        end else begin
                            e = exp_q.pop_front();
                            t = acc_q.pop_front();
                            check48("product", o_product, e);
                            checkint("latency", cyc - t, 24);
                            held = e;
                        end
                    end else begin
                        check48("stable_product", o_product, held);
                    end
                end
                hs_prev    = o_valid && i_ready;
                prev_valid = o_valid;
            end
        end
    end

    task automatic send(input logic [23:0] a, input logic [23:0] b);
        int n;
        logic [47:0] p;
        n = 0;
        while (!o_ready && n < 300) begin
            @(posedge i_clk); #2;
            n++;
        end
        if (!o_ready) begin
            fail_now("ready_timeout");
            return;
        end
        i_data_one = a;
        i_data_two = b;
        i_valid    = 1'b1;
        @(posedge i_clk); #1;
        p = {24'd0, a} * {24'd0, b};
        exp_q.push_back(p);
        acc_q.push_back(cyc);
        #1;
        i_valid    = 1'b0;
        i_data_one = 24'($urandom);
        i_data_two = 24'($urandom);
    endtask

    // Drives i_ready until the output handshake edge has passed.
    task automatic finish_txn(input bit rnd);
        int n;
        n = 0;
        while (n < 400) begin
            i_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (o_valid && i_ready) begin
                @(posedge i_clk); #2;
                return;
            end
            @(posedge i_clk); #2;
            n++;
        end
        fail_now("valid_timeout");
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [23:0] a;
        logic [23:0] b;
        int n;

        repeat (3) @(posedge i_clk);
        #2;
        i_rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            i_ready = ~i_ready;
            @(posedge i_clk); #2;
            check1("idle_ready", o_ready, 1'b1);
            check1("idle_valid", o_valid, 1'b0);
            check48("idle_product", o_product, 48'h0);
        end

        send(24'h800000, 24'h800000); finish_txn(1'b0);
        send(24'hC00000, 24'hC00000); finish_txn(1'b0);
        send(24'hFFFFFF, 24'hFFFFFF); finish_txn(1'b0);

        // Operand and i_valid noise during CALC must not disturb the result.
        send(24'h000000, 24'hABCDEF);
        for (int i = 0; i < 5; i++) begin
            @(posedge i_clk); #2;
            i_valid    = 1'b1;
            i_data_one = 24'($urandom);
            i_data_two = 24'($urandom);
        end
        i_valid = 1'b0;
        finish_txn(1'b0);

        // Back-pressure then back-to-back accept.
        i_ready = 1'b0;
        send(24'h812345, 24'h9ABCDE);
        n = 0;
        while (!o_valid && n < 100) begin
            @(posedge i_clk); #2;
            n++;
        end
        if (!o_valid) fail_now("bp_valid_timeout");
        repeat (10) @(posedge i_clk);
        #2;
        check1("bp_still_valid", o_valid, 1'b1);
        i_ready = 1'b1;
        @(posedge i_clk); #2;
        i_ready = 1'b0;
        check1("bp_ready_next_cycle", o_ready, 1'b1);
        send(24'hA5A5A5, 24'h5A5A5A);
        finish_txn(1'b0);

        for (int i = 0; i < 20; i++) begin
            a = 24'($urandom);
            b = 24'($urandom);
            if (i % 2 == 0) begin
                a = a | 24'h800000;
                b = b | 24'h800000;
            end
            send(a, b);
            finish_txn(1'b1);
        end

        // Reset mid-CALC aborts the operation.
        i_ready = 1'b1;
        send(24'h812345, 24'h9ABCDE);
        repeat (12) @(posedge i_clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        check1("rst_ready", o_ready, 1'b1);
        check1("rst_valid", o_valid, 1'b0);
        check48("rst_product", o_product, 48'h0);
        if (exp_q.size() != 0) begin
            void'(exp_q.pop_back());
            void'(acc_q.pop_back());
        end
        repeat (2) @(posedge i_clk);
        #2;
        i_rst_n = 1'b1;
        repeat (30) @(posedge i_clk);
        #2;
        check1("post_rst_idle", o_ready, 1'b1);
        send(24'h800000, 24'hFFFFFF);
        finish_txn(1'b0);

        repeat (30) @(posedge i_clk);
        #2;
        checkint("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
